// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round count, round-constant table, key-schedule FSM states.
package aes_pkg;

    localparam int unsigned KEY_W = 128;
    localparam int unsigned NR    = 10;

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    // Round constant (top byte of the RCON word) indexed by the index of the key being expanded.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Round-key stream and control bundle between the key schedule and its consumer.
interface aes_key_schedule_if;
    import aes_pkg::*;

    logic             start;
    logic [KEY_W-1:0] key_in;
    logic             rk_ready;
    logic             rk_valid;
    logic [KEY_W-1:0] round_key;
    logic [3:0]       rk_idx;
    logic             busy;
    logic             done;

    // Key schedule side.
    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, round_key, rk_idx, busy, done
    );

    // Controller / round-datapath side.
    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, round_key, rk_idx, busy, done
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (one byte); shared with the SubBytes stage.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion: emits round keys 0..NR over a valid/ready stream,
// deriving each key from the one currently presented (no stored key table).
module aes_key_schedule #(
    parameter int unsigned NR    = aes_pkg::NR,
    parameter int unsigned KEY_W = aes_pkg::KEY_W
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_key_schedule_if.slave  ks
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_e           state_q;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_d;
    logic [3:0]       idx_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic [31:0]      rot_w;
    logic [31:0]      sub_w;
    logic [31:0]      t_w;
    logic [31:0]      w0_d;
    logic [31:0]      w1_d;
    logic [31:0]      w2_d;
    logic [31:0]      w3_d;

    assign accept = valid_q & ks.rk_ready;

    // RotWord of the last word of the current key feeds SubWord.
    assign rot_w = {key_q[23:0], key_q[31:24]};

    aes_sbox u_sbox3 (.in_i(rot_w[31:24]), .out_o(sub_w[31:24]));
    aes_sbox u_sbox2 (.in_i(rot_w[23:16]), .out_o(sub_w[23:16]));
    aes_sbox u_sbox1 (.in_i(rot_w[15:8]),  .out_o(sub_w[15:8]));
    aes_sbox u_sbox0 (.in_i(rot_w[7:0]),   .out_o(sub_w[7:0]));

    // Next round key from the key currently on the output.
    always_comb begin
        t_w   = sub_w ^ {rcon(idx_q), 24'h0};
        w0_d  = key_q[127:96] ^ t_w;
        w1_d  = key_q[95:64]  ^ w0_d;
        w2_d  = key_q[63:32]  ^ w1_d;
        w3_d  = key_q[31:0]   ^ w2_d;
        key_d = {w0_d, w1_d, w2_d, w3_d};
    end

    // Control FSM with key register, index counter and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ks.start) begin
                        key_q   <= ks.key_in;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    // start is not looked at here, so a start coinciding with the
                    // final accept is dropped and re-sampled once back in IDLE.
                    if (accept) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            key_q <= key_d;
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ks.rk_valid  = valid_q;
    assign ks.round_key = key_q;
    assign ks.rk_idx    = idx_q;
    assign ks.busy      = busy_q;
    assign ks.done      = done_q;

endmodule
